// File: rtl/mips_multi_cycle_pkg.sv
// rtl/mips_multi_cycle_pkg.sv - opcodes, funct codes, FSM states and ALU ops for the multi-cycle MIPS
package mips_multi_cycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH, DECODE, EX, RWB, IWB, ADDR, LWMEM, LWWB, SWMEM, BR, JMP, JAL, JR
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    function automatic alu_op_t rtype_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] alu_calc(input alu_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multi-cycle MIPS control FSM and memory strobes
module mips_mc_controller
    import mips_multi_cycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output state_t     o_state,
    output logic       o_mem_read,
    output logic       o_mem_write
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= FETCH;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH: w_next = DECODE;
            DECODE: begin
                case (i_opcode)
                    OP_RTYPE: begin
                        case (i_funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_next = EX;
                            FN_JR:   w_next = JR;
                            default: w_next = FETCH;
                        endcase
                    end
                    OP_ADDI, OP_SLTI: w_next = EX;
                    OP_LW, OP_SW:     w_next = ADDR;
                    OP_BEQ:           w_next = BR;
                    OP_J:             w_next = JMP;
                    OP_JAL:           w_next = JAL;
                    default:          w_next = FETCH;
                endcase
            end
            EX:      w_next = (i_opcode == OP_RTYPE) ? RWB : IWB;
            ADDR:    w_next = (i_opcode == OP_LW) ? LWMEM : SWMEM;
            LWMEM:   w_next = LWWB;
            default: w_next = FETCH;
        endcase
    end

    // Strobes are gated by reset so an abandoned store never reaches memory.
    always_comb begin
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        if (rst) begin
            o_mem_read  = (r_state == FETCH) || (r_state == LWMEM);
            o_mem_write = (r_state == SWMEM);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/mips_multi_cycle.sv
// rtl/mips_multi_cycle.sv - multi-cycle MIPS datapath with unified instruction/data memory port
module mips_multi_cycle
    import mips_multi_cycle_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_out,
    output logic [31:0] adr,
    output logic [31:0] data_in,
    output logic [31:0] inst,
    output logic        MemRead,
    output logic        MemWrite
);

    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu_out, r_mdr;
    logic [31:0] r_rf [32];

    state_t      w_state;
    logic [5:0]  w_opcode, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm_se, w_alu_b, w_alu_y, w_jump_target;
    alu_op_t     w_alu_op;

    assign w_opcode      = r_ir[31:26];
    assign w_rs          = r_ir[25:21];
    assign w_rt          = r_ir[20:16];
    assign w_rd          = r_ir[15:11];
    assign w_funct       = r_ir[5:0];
    assign w_imm_se      = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_jump_target = {r_pc[31:28], r_ir[25:0], 2'b00};

    // lw/sw and addi all resolve to ALU_ADD here, which ADDR relies on.
    assign w_alu_op = (w_opcode == OP_RTYPE) ? rtype_alu(w_funct) :
                      (w_opcode == OP_SLTI)  ? ALU_SLT : ALU_ADD;
    assign w_alu_b  = (w_opcode == OP_RTYPE) ? r_b : w_imm_se;
    assign w_alu_y  = alu_calc(w_alu_op, r_a, w_alu_b);

    mips_mc_controller u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_opcode    (w_opcode),
        .i_funct     (w_funct),
        .o_state     (w_state),
        .o_mem_read  (MemRead),
        .o_mem_write (MemWrite)
    );

    assign adr     = (w_state == LWMEM || w_state == SWMEM) ? r_alu_out : r_pc;
    assign data_in = r_b;
    assign inst    = r_ir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= PC_RESET;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
            r_mdr     <= '0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            case (w_state)
                FETCH: begin
                    r_ir <= data_out;
                    r_pc <= r_pc + 32'd4;
                end
                DECODE: begin
                    r_a       <= r_rf[w_rs];
                    r_b       <= r_rf[w_rt];
                    r_alu_out <= r_pc + {w_imm_se[29:0], 2'b00};
                end
                EX, ADDR: r_alu_out <= w_alu_y;
                RWB:   if (w_rd != 5'd0) r_rf[w_rd] <= r_alu_out;
                IWB:   if (w_rt != 5'd0) r_rf[w_rt] <= r_alu_out;
                LWMEM: r_mdr <= data_out;
                LWWB:  if (w_rt != 5'd0) r_rf[w_rt] <= r_mdr;
                BR:    if (r_a == r_b) r_pc <= r_alu_out;
                JMP:   r_pc <= w_jump_target;
                JAL: begin
                    r_pc      <= w_jump_target;
                    r_rf[31]  <= r_pc;
                end
                JR:    r_pc <= r_a;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multi_cycle.sv
// tb/tb_mips_multi_cycle.sv - ISA-level reference model bench for mips_multi_cycle
module tb_mips_multi_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_out, adr, data_in, inst;
    logic        MemRead, MemWrite;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem  [1024];
    logic [31:0] mmem [1024];
    logic [31:0] mrf  [32];
    logic [31:0] mpc;

    always #5 clk = ~clk;

    mips_multi_cycle #(.PC_RESET(32'h0)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_out (data_out),
        .adr      (adr),
        .data_in  (data_in),
        .inst     (inst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite)
    );

    always_comb data_out = MemRead ? mem[adr[11:2]] : 32'h0;
    always @(posedge clk) if (MemWrite) mem[adr[11:2]] <= data_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        logic [4:0] s, t, d;
        s = 5'(rs); t = 5'(rt); d = 5'(rd);
        return {6'h00, s, t, d, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        logic [4:0] s, t;
        s = 5'(rs); t = 5'(rt);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic mwr(input logic [4:0] idx, input logic [31:0] v);
        if (idx != 5'd0) mrf[idx] = v;
    endtask

    // Architectural step: executes one instruction on the model and reports its cycle cost.
    task automatic model_step(output int ncyc, output bit st, output logic [31:0] sa, output logic [31:0] sd);
        logic [31:0] iw, a, b, se, npc, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        iw = mmem[mpc[11:2]];
        op = iw[31:26]; rs = iw[25:21]; rt = iw[20:16]; rd = iw[15:11]; fn = iw[5:0];
        se = {{16{iw[15]}}, iw[15:0]};
        a = mrf[rs]; b = mrf[rt]; npc = mpc + 4;
        st = 0; sa = 0; sd = 0; ncyc = 2;
        case (op)
            6'h00: case (fn)
                6'h20: begin mwr(rd, a + b); ncyc = 4; end
                6'h22: begin mwr(rd, a - b); ncyc = 4; end
                6'h24: begin mwr(rd, a & b); ncyc = 4; end
                6'h25: begin mwr(rd, a | b); ncyc = 4; end
                6'h2A: begin mwr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0); ncyc = 4; end
                6'h08: begin npc = a; ncyc = 3; end
                default: ncyc = 2;
            endcase
            6'h08: begin mwr(rt, a + se); ncyc = 4; end
            6'h0A: begin mwr(rt, ($signed(a) < $signed(se)) ? 32'd1 : 32'd0); ncyc = 4; end
            6'h23: begin ea = a + se; mwr(rt, mmem[ea[11:2]]); ncyc = 5; end
            6'h2B: begin ea = a + se; st = 1; sa = ea; sd = b; mmem[ea[11:2]] = b; ncyc = 4; end
            6'h04: begin if (a == b) npc = npc + (se << 2); ncyc = 3; end
            6'h02: begin npc = {npc[31:28], iw[25:0], 2'b00}; ncyc = 3; end
            6'h03: begin mwr(5'd31, npc); npc = {npc[31:28], iw[25:0], 2'b00}; ncyc = 3; end
            default: ncyc = 2;
        endcase
        mpc = npc;
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        int rs, rt, rd;
        logic [5:0] fns [5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        k  = $urandom_range(0, 11);
        rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        case (k)
            0, 1, 2, 3, 4: return rtype(rs, rt, rd, fns[$urandom_range(0, 4)]);
            5, 11: return itype(6'h08, rs, rt, 16'($urandom));
            6:  return itype(6'h0A, rs, rt, 16'($urandom));
            7:  return itype(6'h23, 0, rt, 16'(32'hC80 + 4 * $urandom_range(0, 31)));
            8:  return itype(6'h2B, 0, rt, 16'(32'hC80 + 4 * $urandom_range(0, 31)));
            9:  return itype(6'h04, rs, rt, 16'($urandom_range(0, 3)));
            default: return ($urandom_range(0, 1) == 0) ? 32'hFC00_0000 | 32'($urandom_range(0, 255))
                                                        : rtype(rs, rt, rd, 6'h3F);
        endcase
    endfunction

    task automatic start(input string tag);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 1024; i++) mmem[i] = mem[i];
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        mpc = 32'h0;
        @(negedge clk);
        #1;
        chk({tag, "_rst_adr"}, adr, 32'h0);
        chk({tag, "_rst_rd"}, {31'b0, MemRead}, 32'h0);
        chk({tag, "_rst_wr"}, {31'b0, MemWrite}, 32'h0);
        chk({tag, "_rst_inst"}, inst, 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input string tag, input int steps);
        int ncyc;
        bit st;
        logic [31:0] sa, sd, pc0, iw;
        for (int s = 0; s < steps; s++) begin
            pc0 = mpc;
            iw  = mmem[pc0[11:2]];
            model_step(ncyc, st, sa, sd);
            #1;
            chk({tag, "_fetch_adr"}, adr, pc0);
            chk({tag, "_fetch_rd"}, {31'b0, MemRead}, 32'h1);
            @(negedge clk);
            for (int c = 1; c < ncyc; c++) begin
                #1;
                if (c == 1) chk({tag, "_ir"}, inst, iw);
                if (st && c == 3) begin
                    chk({tag, "_sw_we"}, {31'b0, MemWrite}, 32'h1);
                    chk({tag, "_sw_adr"}, adr, sa);
                    chk({tag, "_sw_data"}, data_in, sd);
                end else begin
                    chk({tag, "_we_idle"}, {31'b0, MemWrite}, 32'h0);
                end
                @(negedge clk);
            end
        end
        #1;
        chk({tag, "_end_pc"}, adr, mpc);
        for (int i = 0; i < 32; i++) chk({tag, "_rf"}, dut.r_rf[i], mrf[i]);
        for (int i = 800; i < 832; i++) chk({tag, "_dmem"}, mem[i], mmem[i]);
    endtask

    initial begin
        rst = 1'b0;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = itype(6'h08, 0, 1, 16'd5);
        mem[1] = itype(6'h08, 0, 2, 16'd7);
        mem[2] = rtype(1, 2, 3, 6'h20);
        mem[3] = itype(6'h2B, 0, 3, 16'd8);
        mem[4] = itype(6'h23, 0, 4, 16'd8);
        mem[5] = itype(6'h0A, 0, 5, 16'hFFFF);
        mem[6] = itype(6'h08, 0, 0, 16'd9);
        mem[7] = 32'hFC00_0000;
        start("alu");
        run("alu", 8);
        chk("add_r3", dut.r_rf[3], 32'd12);
        chk("lw_r4", dut.r_rf[4], 32'd12);
        chk("slti_r5", dut.r_rf[5], 32'd0);
        chk("r0_zero", dut.r_rf[0], 32'd0);
        chk("sw_mem8", mem[2], 32'd12);

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]  = itype(6'h08, 0, 1, 16'd1);
        mem[1]  = itype(6'h08, 0, 2, 16'd2);
        mem[2]  = itype(6'h04, 1, 2, 16'd5);
        mem[3]  = rtype(0, 0, 0, 6'h3F);
        mem[4]  = itype(6'h04, 1, 1, 16'd2);
        mem[7]  = jtype(6'h02, 26'd8);
        mem[8]  = jtype(6'h03, 26'd16);
        mem[16] = rtype(31, 0, 0, 6'h08);
        mem[9]  = itype(6'h08, 0, 6, 16'd3);
        start("flow");
        run("flow", 9);
        chk("jal_r31", dut.r_rf[31], 32'h24);
        chk("after_jr_r6", dut.r_rf[6], 32'd3);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 700; i++) mem[i] = rand_instr();
            for (int i = 700; i < 1024; i++) mem[i] = $urandom;
            start("rnd");
            run("rnd", 150);
        end

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = itype(6'h08, 0, 1, 16'h55);
        mem[1] = itype(6'h2B, 0, 1, 16'hC80);
        start("rst");
        repeat (7) @(negedge clk);
        #1;
        chk("rst_pre_we", {31'b0, MemWrite}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_mid_we", {31'b0, MemWrite}, 32'h0);
        chk("rst_mid_adr", adr, 32'h0);
        @(negedge clk);
        #1;
        chk("rst_no_store", mem[800], 32'h0);
        chk("rst_rf1", dut.r_rf[1], 32'h0);
        rst = 1'b1;
        #1;
        chk("rst_refetch_adr", adr, 32'h0);
        chk("rst_refetch_rd", {31'b0, MemRead}, 32'h1);
        @(negedge clk);
        #1;
        chk("rst_refetch_ir", inst, mem[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multi_cycle.md
MIPS_MULTI_CYCLE -- requirements
Module: mips_multi_cycle

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, the address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 data_out  input  32  read data returned by the unified instruction/data memory.
REQ-005 adr  output  32  memory byte address; word-aligned.
REQ-006 data_in  output  32  memory write data (the B register).
REQ-007 inst  output  32  current instruction register (IR).
REQ-008 MemRead  output  1  memory read strobe.
REQ-009 MemWrite  output  1  memory write strobe; the memory writes on the rising edge.

Function
REQ-010 The core SHALL be a multi-cycle MIPS using one unified memory for instructions and data; the memory read is combinational in the same cycle as adr and MemRead.
REQ-011 Supported encodings SHALL be:
- R-type op 000000 with funct add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000.
- I-type addi 001000, slti 001010, lw 100011, sw 101011, beq 000100.
- J-type j 000010, jal 000011.
REQ-012 FETCH SHALL drive adr=PC and MemRead=1, then IR<=data_out and PC<=PC+4.
REQ-013 DECODE SHALL do A<=rf[rs], B<=rf[rt], ALUOut<=PC+(signext(imm)<<2), and branch on opcode.
REQ-014 Execute paths SHALL be:
- R-type: EX ALUOut<=A op B, then RWB rf[rd]<=ALUOut.
- addi/slti: EX ALUOut<=A op signext(imm), then IWB rf[rt]<=ALUOut.
- lw/sw: ADDR ALUOut<=A+signext(imm).
- lw: LWMEM adr=ALUOut, MemRead=1, MDR<=data_out; then LWWB rf[rt]<=MDR.
- sw: SWMEM adr=ALUOut, data_in=B, MemWrite=1.
- beq: BR if A==B then PC<=ALUOut.
- j: PC<={PC[31:28],target,2'b00}.
- jal: rf[31]<=PC and PC<=the same jump target.
- jr: PC<=A.
- Every path SHALL return to FETCH.
REQ-015 Cycles per instruction SHALL be: R-type/addi/slti/sw 4, lw 5, beq/j/jal/jr 3.
REQ-016 slt and slti SHALL compare signed 32-bit values and write 1 or 0; add, addi and sub SHALL wrap modulo 2^32 with no overflow trap.
REQ-017 rf[0] SHALL read 0 always, and writes to it SHALL be ignored.
REQ-018 Unknown opcode or funct SHALL act as a NOP: DECODE returns to FETCH with no architectural change.
REQ-019 MemRead and MemWrite SHALL never be asserted together, and both SHALL be 0 outside FETCH, LWMEM and SWMEM.
REQ-020 adr SHALL be PC in FETCH and ALUOut in memory states; in all other states adr SHALL be PC.

Reset
REQ-021 While rst=0, asynchronously: state=FETCH, PC=PC_RESET, IR/A/B/ALUOut/MDR=0, all 32 registers=0, MemRead=MemWrite=0.
REQ-022 Reset asserted mid-instruction SHALL abandon it; a pending write SHALL not occur after the reset edge.
REQ-023 The first fetch SHALL occur on the first rising clk edge after rst goes high.

Structure
REQ-024 A shared package SHALL hold the opcode and funct constants, the state encoding (FETCH, DECODE, EX, RWB, IWB, ADDR, LWMEM, LWWB, SWMEM, BR, JMP, JAL, JR), and the ALU operation codes.
REQ-025 The controller FSM SHALL be one sub-module, mips_mc_controller; the datapath (register file, ALU, registers, muxes) SHALL stay in mips_multi_cycle.
REQ-026 The companion data_mem (adr, data_in, MemRead, MemWrite, clk, data_out) SHALL satisfy:
- word-indexed by adr[..:2];
- combinational read gated by MemRead, returning 0 otherwise;
- synchronous write on the rising clk edge when MemWrite=1;
- at least 4096 words, loaded from a hex file.

Verification
REQ-027 addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> rf[3]=12, each instruction taking 4 cycles.
REQ-028 sw $3,8($0) then lw $4,8($0) -> MemWrite pulses once with adr=8 and data_in=12; rf[4]=12; lw takes 5 cycles.
REQ-029 beq $1,$1,+2 at PC=0x10 -> PC=0x1C after 3 cycles; beq with unequal operands -> PC=0x14.
REQ-030 jal at 0x20 to target 0x40, then jr $31 -> rf[31]=0x24, and the next fetch after jr is from 0x24.
REQ-031 slti $5,$0,-1 -> rf[5]=0; addi $0,$0,9 -> rf[0] stays 0; an unknown opcode changes no state.
REQ-032 rst driven low during SWMEM -> no memory write; PC=0 and the next fetch is from address 0.
